// File: rtl/edge_det_pkg.sv
// Shared encodings for the multi-channel edge/event detector.
package edge_det_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rpt_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One input bit: synchronizer, debounce filter, edge event and auto-repeat FSM.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       repeat_en,
  output logic       evt,
  output logic       level
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RCNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_RATE)) + 1;
  localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp_p0;
  logic [CNT_W-1:0]       cnt;
  logic [RCNT_W-1:0]      rcnt;
  rpt_state_t             state;
  logic                   accept, rise, fall, rpt_evt, rise_en, fall_en;

  assign rise_en = (mode != EDGE_NONE) && (mode != EDGE_FALL);
  assign fall_en = (mode == EDGE_FALL) || (mode == EDGE_BOTH);

  // Debounce decision on the registered sample; the extra stage puts the
  // level change exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the input.
  assign accept = (samp_p0 != level) && (cnt == DB_LAST);
  assign rise   = accept && samp_p0;
  assign fall   = accept && !samp_p0;

  always_comb begin
    rpt_evt = 1'b0;
    case (state)
      HOLD:    rpt_evt = level && !fall && (rcnt == DELAY_LAST);
      REPEAT:  rpt_evt = level && !fall && (rcnt == RATE_LAST);
      default: rpt_evt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      samp_p0 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      evt     <= 1'b0;
      rcnt    <= '0;
      state   <= IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      samp_p0 <= sync_q[SYNC_STAGES-1];

      if (samp_p0 == level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        level <= samp_p0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      evt <= (rise && rise_en) || (fall && fall_en) || (rpt_evt && repeat_en && rise_en);

      // Repeat FSM runs independently of repeat_en so enabling mid-hold joins the current phase.
      case (state)
        IDLE: begin
          if (rise) begin
            state <= HOLD;
            rcnt  <= '0;
          end
        end
        HOLD: begin
          if (!level || fall) begin
            state <= IDLE;
          end else if (rcnt == DELAY_LAST) begin
            state <= REPEAT;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!level || fall) begin
            state <= IDLE;
          end else if (rcnt == RATE_LAST) begin
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_edge_event_detector.sv
// N independent debounced edge/repeat event channels with a combined event flag.
module multi_edge_event_detector
  import edge_det_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   I,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   repeat_en,
  output logic [N_CH-1:0]   O,
  output logic [N_CH-1:0]   level,
  output logic              any_event
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (I[i]),
      .mode     (mode[2*i +: 2]),
      .repeat_en(repeat_en[i]),
      .evt      (O[i]),
      .level    (level[i])
    );
  end

  assign any_event = |O;

endmodule

// File: tb/tb_multi_edge_event_detector.sv
// Directed bench for multi_edge_event_detector with default parameters.
module tb_multi_edge_event_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] I;
  logic [7:0] mode;
  logic [3:0] repeat_en;
  logic [3:0] O;
  logic [3:0] level;
  logic       any_event;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multi_edge_event_detector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I        (I),
    .mode     (mode),
    .repeat_en(repeat_en),
    .O        (O),
    .level    (level),
    .any_event(any_event)
  );

  task automatic test_reset();
    rst_n     = 1'b0;
    I         = 4'hF;
    mode      = 8'hFF;
    repeat_en = 4'hF;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (O !== 4'h0 || level !== 4'h0 || any_event !== 1'b0)
      $display("FAIL reset_hold O=%b level=%b any=%b expected 0000/0000/0", O, level, any_event);
    else passed++;
    I = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (O !== 4'h0 || level !== 4'h0 || any_event !== 1'b0)
      $display("FAIL reset_release O=%b level=%b any=%b expected 0000/0000/0", O, level, any_event);
    else passed++;
  endtask

  task automatic test_rise_only();
    logic exp_o, exp_l;
    mode      = 8'b01_01_01_01;
    repeat_en = 4'h0;
    @(negedge clk);
    I[0] = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk);
      #1;
      exp_o = (k == 6);
      exp_l = (k >= 6 && k <= 9);
      total++;
      if (O[0] !== exp_o || level[0] !== exp_l || any_event !== exp_o)
        $display("FAIL rise_only k=%0d O0=%b level0=%b any=%b expected %b/%b/%b",
                 k, O[0], level[0], any_event, exp_o, exp_l, exp_o);
      else passed++;
      if (k == 3) I[0] = 1'b0;
    end
  endtask

  task automatic test_both_edges();
    logic exp_o, exp_l;
    mode = 8'b01_01_11_01;
    @(negedge clk);
    I[1] = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk);
      #1;
      exp_o = (k == 6) || (k == 26);
      exp_l = (k >= 6 && k <= 25);
      total++;
      if (O[1] !== exp_o || level[1] !== exp_l)
        $display("FAIL both_edges k=%0d O1=%b level1=%b expected %b/%b", k, O[1], level[1], exp_o, exp_l);
      else passed++;
      if (k == 19) I[1] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    mode = 8'b01_11_01_01;
    @(negedge clk);
    I[2] = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (O[2] !== 1'b0 || level[2] !== 1'b0)
        $display("FAIL glitch k=%0d O2=%b level2=%b expected 0/0", k, O[2], level[2]);
      else passed++;
      if (k == 5) begin
        total++;
        if (dut.g_ch[2].u_ch.cnt !== 2'd3)
          $display("FAIL glitch_cnt_peak cnt=%0d expected 3", dut.g_ch[2].u_ch.cnt);
        else passed++;
      end
      if (k == 2) I[2] = 1'b0;
    end
    total++;
    if (dut.g_ch[2].u_ch.cnt !== 2'd0)
      $display("FAIL glitch_cnt_clear cnt=%0d expected 0", dut.g_ch[2].u_ch.cnt);
    else passed++;
  endtask

  task automatic test_repeat();
    logic exp_o, exp_l;
    mode      = 8'b01_01_01_01;
    repeat_en = 4'b1000;
    @(negedge clk);
    I[3] = 1'b1;
    for (int k = 0; k <= 44; k++) begin
      @(posedge clk);
      #1;
      exp_o = (k == 6) || (k == 14) || (k == 18) || (k == 22) || (k == 26) || (k == 30) || (k == 34);
      exp_l = (k >= 6 && k <= 35);
      total++;
      if (O[3] !== exp_o || level[3] !== exp_l)
        $display("FAIL repeat k=%0d O3=%b level3=%b expected %b/%b", k, O[3], level[3], exp_o, exp_l);
      else passed++;
      if (k == 29) I[3] = 1'b0;
    end
    repeat_en = 4'h0;
  endtask

  task automatic test_reset_mid_hold();
    logic exp_o, exp_l;
    mode = 8'b01_01_01_01;
    @(negedge clk);
    I[0] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (level[0] !== 1'b1)
      $display("FAIL pre_reset_level level0=%b expected 1", level[0]);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (O !== 4'h0 || level !== 4'h0)
      $display("FAIL reset_assert O=%b level=%b expected 0000/0000", O, level);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (O !== 4'h0 || level !== 4'h0)
        $display("FAIL reset_during k=%0d O=%b level=%b expected 0000/0000", k, O, level);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1;
      exp_o = (k == 6);
      exp_l = (k >= 6);
      total++;
      if (O[0] !== exp_o || level[0] !== exp_l)
        $display("FAIL after_reset k=%0d O0=%b level0=%b expected %b/%b", k, O[0], level[0], exp_o, exp_l);
      else passed++;
    end
    I[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_o, exp_l;
    mode = 8'b01_01_01_01;
    @(negedge clk);
    I = 4'hF;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp_o = (k == 6) ? 4'hF : 4'h0;
      total++;
      if (O !== exp_o || any_event !== (k == 6))
        $display("FAIL simul_all k=%0d O=%b any=%b expected %b/%b", k, O, any_event, exp_o, (k == 6));
      else passed++;
    end
    I = 4'h0;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (level !== 4'h0 || O !== 4'h0)
      $display("FAIL simul_release level=%b O=%b expected 0000/0000", level, O);
    else passed++;
    mode = 8'b01_00_01_01;
    @(negedge clk);
    I = 4'hF;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp_o = (k == 6) ? 4'b1011 : 4'h0;
      exp_l = (k >= 6) ? 4'hF : 4'h0;
      total++;
      if (O !== exp_o || level !== exp_l || any_event !== (k == 6))
        $display("FAIL simul_masked k=%0d O=%b level=%b any=%b expected %b/%b/%b",
                 k, O, level, any_event, exp_o, exp_l, (k == 6));
      else passed++;
    end
    I = 4'h0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_rise_only();
    test_both_edges();
    test_glitch();
    test_repeat();
    test_reset_mid_hold();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
